glitch_scheduler: RTL

Sequencer that drives the trigger input of the single-cycle clock-glitch block. Once armed, it waits for an external trigger edge from the target, counts a programmed number of target-clock rising edges, then emits a programmed number of glitch-trigger pulses separated by a programmed gap, also measured in target-clock edges. It runs in the fast glitch `clk` domain, between the host configuration registers and the glitch generator.

---
 rtl/glitch_pkg.sv | 17 +
 rtl/edge_sync.sv | 36 +++
 rtl/glitch_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/glitch_pkg.sv
// glitch_pkg: shared definitions for the glitch trigger scheduler.
//   state_t     - sequencer states
//   SYNC_STAGES - depth of the asynchronous-input synchronizers
package glitch_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    FIRE,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: synchronizes an asynchronous level into clk and flags its
// rising edges.
//   clk      - sampling clock
//   rst      - asynchronous active-high reset
//   async_in - asynchronous input level
//   rise     - one-cycle high for each synchronized rising edge of async_in
module edge_sync
  import glitch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/glitch_scheduler.sv
// glitch_scheduler: after arm, waits for a target trigger edge, counts
// target-clock edges, then emits cfg_count glitch-trigger pulses spaced by
// cfg_gap target edges.
//   clk, rst           - glitch clock, asynchronous active-high reset
//   arm, abort         - start / cancel requests
//   ext_trig           - asynchronous target trigger (rising edge)
//   clean_target_clock - asynchronous target clock
//   cfg_delay/count/gap- configuration, latched on arm
//   glitch_trig        - PULSE_W-cycle trigger to the glitch generator
//   armed, busy, done  - registered status decoded from the state
module glitch_scheduler
  import glitch_pkg::*;
#(
  parameter int unsigned DELAY_W = 16,
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned PULSE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic               ext_trig,
  input  logic               clean_target_clock,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic [GAP_W-1:0]   cfg_gap,
  output logic               glitch_trig,
  output logic               armed,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic trig_rise, tclk_rise;

  edge_sync u_trig_sync (.clk(clk), .rst(rst), .async_in(ext_trig),           .rise(trig_rise));
  edge_sync u_tclk_sync (.clk(clk), .rst(rst), .async_in(clean_target_clock), .rise(tclk_rise));

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] lat_delay_q, lat_delay_d, dly_q, dly_d;
  logic [GAP_W-1:0]   lat_gap_q, lat_gap_d, gap_q, gap_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               glitch_trig_q, glitch_trig_d;
  logic               armed_q, armed_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d     = state_q;
    lat_delay_d = lat_delay_q;
    lat_gap_d   = lat_gap_q;
    dly_d       = dly_q;
    gap_d       = gap_q;
    rem_d       = rem_q;
    pcnt_d      = pcnt_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (arm) begin
          lat_delay_d = cfg_delay;
          lat_gap_d   = cfg_gap;
          rem_d       = cfg_count;
          state_d     = (cfg_count == '0) ? DONE : ARMED;
        end
        // A target edge coinciding with the trigger is dropped because the
        // delay counter is only loaded here, not decremented.
        ARMED: if (trig_rise) begin
          dly_d   = lat_delay_q;
          state_d = DELAY;
        end
        DELAY: begin
          if (dly_q == '0) begin
            pcnt_d  = '0;
            state_d = FIRE;
          end else if (tclk_rise) begin
            dly_d = dly_q - DELAY_W'(1);
          end
        end
        FIRE: begin
          if (pcnt_q == PCNT_W'(PULSE_W - 1)) begin
            if (rem_q != '0) rem_d = rem_q - COUNT_W'(1);
            if (rem_q <= COUNT_W'(1)) begin
              state_d = DONE;
            end else begin
              gap_d   = (lat_gap_q == '0) ? GAP_W'(1) : lat_gap_q;
              state_d = GAP;
            end
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            pcnt_d  = '0;
            state_d = FIRE;
          end else if (tclk_rise) begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    glitch_trig_d = (state_d == FIRE);
    armed_d       = (state_d == ARMED);
    busy_d        = (state_d == DELAY) || (state_d == FIRE) || (state_d == GAP);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lat_delay_q   <= '0;
      lat_gap_q     <= '0;
      dly_q         <= '0;
      gap_q         <= '0;
      rem_q         <= '0;
      pcnt_q        <= '0;
      glitch_trig_q <= 1'b0;
      armed_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_delay_q   <= lat_delay_d;
      lat_gap_q     <= lat_gap_d;
      dly_q         <= dly_d;
      gap_q         <= gap_d;
      rem_q         <= rem_d;
      pcnt_q        <= pcnt_d;
      glitch_trig_q <= glitch_trig_d;
      armed_q       <= armed_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign glitch_trig = glitch_trig_q;
  assign armed       = armed_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
